uart_tx: RTL

//  8N1 UART transmitter with a small input FIFO. It is the outbound end of the serial link and the

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO on a valid/ready handshake.
// Idle-high registered tx line; frames run back-to-back while bytes are queued.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int BW    = $clog2(CLKS_PER_BIT);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_full, fifo_empty, push, pop;
   logic [7:0]    fifo_rd;

   assign fifo_full  = (count == CNT_FULL);
   assign fifo_empty = (count == '0);
   assign fifo_rd    = mem[rd_ptr];
   assign tx_ready   = !rst && !fifo_full;
   assign push       = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Serialiser
   state_t        state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          tx_n, baud_end;

   assign baud_end = (baud_cnt == BAUD_MAX);
   assign busy     = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         shreg    <= shreg_n;
         tx       <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_idx;
      shreg_n = shreg;
      tx_n    = tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            baud_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_n = fifo_rd;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = shreg[0];
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  // shift so the next data bit is always at shreg[1] -> shreg[0]
                  bit_n   = bit_idx + 1'b1;
                  shreg_n = {1'b0, shreg[7:1]};
                  tx_n    = shreg[1];
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_n = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_n = fifo_rd;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            tx_n    = 1'b1;
            baud_n  = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule
